i2c_tmp101_controller: RTL and testbench

//  Sequencer for the I2C data unit (8-bit shift register + SDA mux) talking to a TMP101 sensor.

---
 rtl/i2c_tmp101_controller.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_tmp101_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tmp101_controller.sv
// i2c_tmp101_controller: SCL/SDA sequencer for a TMP101 pointer write or 2-byte read.
// Optional I2C_NACK_RETRY_EN: retry an address NACK up to 3 times before flagging AckError.
module i2c_tmp101_controller #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic        RdWr,
  input  logic [6:0]  SlaveAddr,
  input  logic [7:0]  PtrByte,
  output logic        Busy,
  output logic        Done,
  output logic        AckError,
  output logic [15:0] RxData,
  output logic        SCL,
  output logic        WriteLoad,
  output logic [7:0]  SentData,
  input  logic [7:0]  ReceivedData,
  output logic        ShiftorHold,
  output logic        ReadOrWrite,
  output logic        Select,
  output logic        StartStopAck
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WBYTE, WBYTE_ACK,
    RMSB, MACK, RLSB, MNACK, STOP, DONE
  } state_t;

  state_t state, next;

  logic [DIV_W-1:0] q_cnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic             rd;
  logic             retry;
  logic [7:0]       ptr;
  logic [7:0]       rx_msb;
  logic [7:0]       rx_lsb;
  logic             q_end;
  logic             slot_end;
  logic             samp;
  logic             mid;
  logic             last_bit;
  logic             nack;
`ifdef I2C_NACK_RETRY_EN
  logic [1:0]       tries;
`endif

  assign q_end    = q_cnt == DIV_W'(CLK_DIV - 1);
  assign slot_end = q_end && qtr == 2'd3;
  assign samp     = q_end && qtr == 2'd2;
  assign mid      = qtr == 2'd1 || qtr == 2'd2;
  assign last_bit = slot_end && bit_cnt == 3'd0;
  assign nack     = ReceivedData[0];
  assign Busy     = state != IDLE && state != DONE;
  assign Done     = state == DONE;

  always_comb begin
    next         = state;
    SCL          = 1'b1;
    Select       = 1'b1;
    StartStopAck = 1'b1;
    ReadOrWrite  = 1'b0;
    ShiftorHold  = 1'b0;
    unique case (state)
      IDLE: if (Go) next = START;
      START: begin
        SCL          = qtr != 2'd3;
        StartStopAck = qtr < 2'd2;
        if (slot_end) next = ADDR;
      end
      ADDR, WBYTE: begin
        SCL         = mid;
        Select      = 1'b0;
        ShiftorHold = slot_end;
        if (last_bit)
          next = (state == ADDR) ? ADDR_ACK : WBYTE_ACK;
      end
      ADDR_ACK: begin
        SCL         = mid;
        ReadOrWrite = 1'b1;
        ShiftorHold = samp;
        if (slot_end)
          next = nack ? STOP : (rd ? RMSB : WBYTE);
      end
      WBYTE_ACK: begin
        SCL         = mid;
        ReadOrWrite = 1'b1;
        ShiftorHold = samp;
        if (slot_end) next = STOP;
      end
      RMSB, RLSB: begin
        SCL         = mid;
        ReadOrWrite = 1'b1;
        ShiftorHold = samp;
        if (last_bit)
          next = (state == RMSB) ? MACK : MNACK;
      end
      MACK: begin
        SCL          = mid;
        StartStopAck = 1'b0;
        if (slot_end) next = RLSB;
      end
      MNACK: begin
        SCL = mid;
        if (slot_end) next = STOP;
      end
      STOP: begin
        SCL          = qtr != 2'd0;
        StartStopAck = qtr[1];
        if (slot_end) next = retry ? START : DONE;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      q_cnt     <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      rd        <= 1'b0;
      retry     <= 1'b0;
      ptr       <= '0;
      rx_msb    <= '0;
      rx_lsb    <= '0;
      AckError  <= 1'b0;
      RxData    <= '0;
      SentData  <= '0;
      WriteLoad <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      tries     <= '0;
`endif
    end else begin
      state     <= next;
      WriteLoad <= 1'b0;
      if (state == IDLE || state == DONE) begin
        q_cnt <= '0;
        qtr   <= '0;
      end else if (q_end) begin
        q_cnt <= '0;
        qtr   <= qtr + 2'd1;
      end else begin
        q_cnt <= q_cnt + DIV_W'(1);
      end
      if (state == IDLE && Go) begin
        rd        <= RdWr;
        ptr       <= PtrByte;
        SentData  <= {SlaveAddr, RdWr};
        WriteLoad <= 1'b1;
        AckError  <= 1'b0;
        bit_cnt   <= 3'd7;
        retry     <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
        tries     <= '0;
`endif
      end
      if (slot_end) begin
        unique case (state)
          ADDR, WBYTE: bit_cnt <= bit_cnt - 3'd1;
          RMSB: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) rx_msb <= ReceivedData;
          end
          RLSB: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) rx_lsb <= ReceivedData;
          end
          ADDR_ACK: begin
            if (nack) begin
`ifdef I2C_NACK_RETRY_EN
              if (tries != 2'd3) begin
                tries <= tries + 2'd1;
                retry <= 1'b1;
              end else begin
                AckError <= 1'b1;
              end
`else
              AckError <= 1'b1;
`endif
            end else if (!rd) begin
              SentData  <= ptr;
              WriteLoad <= 1'b1;
            end
          end
          WBYTE_ACK: if (nack) AckError <= 1'b1;
          MNACK: RxData <= {rx_msb, rx_lsb};
          STOP: begin
            if (retry) begin
              retry     <= 1'b0;
              WriteLoad <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_tmp101_controller.sv
// Bench for i2c_tmp101_controller: data-unit shift register and TMP101 slave on a wired-AND SDA.
// Expected bytes, acks, latency and status come from a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_tmp101_controller;
  localparam logic [6:0] SLV = 7'h48;
`ifdef I2C_NACK_RETRY_EN
  localparam int TRIES = 4;
`else
  localparam int TRIES = 1;
`endif

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Go = 1'b0;
  logic        RdWr = 1'b0;
  logic [6:0]  SlaveAddr = '0;
  logic [7:0]  PtrByte = '0;
  logic        Busy, Done, AckError, SCL, WriteLoad;
  logic        ShiftorHold, ReadOrWrite, Select, StartStopAck;
  logic [15:0] RxData;
  logic [7:0]  SentData, ReceivedData;

  logic [7:0]  sr;
  logic        sda;
  logic        sl_drive = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] rx_model = '0;

  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_frame = 1'b0, skip_fall = 1'b0;
  logic        addressed = 1'b0, rw = 1'b0, mack = 1'b0, sending = 1'b0;
  int          bitn = 0, byten = 0, starts = 0, stops = 0;
  logic [7:0]  shreg = '0, txb = '0, rd0 = '0, rd1 = '0;
  logic [7:0]  bus_q[$];
  logic        ack_q[$];

  i2c_tmp101_controller #(.CLK_DIV(4), .DIV_W(8)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .RdWr(RdWr),
    .SlaveAddr(SlaveAddr), .PtrByte(PtrByte),
    .Busy(Busy), .Done(Done), .AckError(AckError),
    .RxData(RxData), .SCL(SCL), .WriteLoad(WriteLoad),
    .SentData(SentData), .ReceivedData(ReceivedData),
    .ShiftorHold(ShiftorHold), .ReadOrWrite(ReadOrWrite),
    .Select(Select), .StartStopAck(StartStopAck)
  );

  always #5 clock = ~clock;

  assign ReceivedData = sr;
  assign sda = (ReadOrWrite ? 1'b1 : (Select ? StartStopAck : sr[7])) & sl_drive;

  always @(posedge clock or negedge Reset)
    if (!Reset) sr <= '0;
    else if (WriteLoad) sr <= SentData;
    else if (ShiftorHold) sr <= {sr[6:0], sda};

  // Slave: decodes START/STOP, bits on SCL rise, changes its SDA drive on SCL fall
  always @(negedge clock) begin
    if (!Reset) begin
      sl_drive = 1'b1; in_frame = 1'b0; sending = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (SCL && prev_scl && prev_sda && !sda) begin
        starts++; in_frame = 1'b1; skip_fall = 1'b1;
        bitn = 0; byten = 0; addressed = 1'b0; sending = 1'b0; sl_drive = 1'b1;
      end else if (SCL && prev_scl && !prev_sda && sda) begin
        stops++; in_frame = 1'b0; sending = 1'b0; sl_drive = 1'b1;
      end else if (in_frame && SCL && !prev_scl) begin
        if (bitn < 8) shreg = {shreg[6:0], sda};
        else begin mack = sda; ack_q.push_back(sda); end
      end else if (in_frame && !SCL && prev_scl) begin
        if (skip_fall) skip_fall = 1'b0;
        else begin
          bitn++;
          if (bitn == 8) begin
            bus_q.push_back(shreg);
            sending = 1'b0;
            if (byten == 0) begin
              addressed = shreg[7:1] == SLV; rw = shreg[0];
              sl_drive = !addressed;
            end else if (!rw) sl_drive = !addressed;
            else sl_drive = 1'b1;
          end else if (bitn == 9) begin
            bitn = 0; byten++;
            if (addressed && rw && byten <= 2 && (byten == 1 || !mack)) begin
              txb = (byten == 1) ? rd0 : rd1;
              sending = 1'b1; sl_drive = txb[7];
            end else begin
              sending = 1'b0; sl_drive = 1'b1;
            end
          end else if (sending) sl_drive = txb[7-bitn];
        end
      end
      prev_scl = SCL; prev_sda = sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic r, input logic [6:0] addr, input logic [7:0] p,
                         input logic [7:0] d0, input logic [7:0] d1, input bit hold);
    logic [7:0] eb[$];
    logic       ea[$];
    logic [7:0] ab;
    int slots, cyc, busy_low, att;
    bit hit;
    hit = addr == SLV;
    att = hit ? 1 : TRIES;
    ab = {addr, r};
    for (int i = 0; i < att; i++) begin
      eb.push_back(ab);
      if (!hit) ea.push_back(1'b1);
    end
    if (hit) begin
      ea.push_back(1'b0);
      if (r) begin
        eb.push_back(d0); ea.push_back(1'b0);
        eb.push_back(d1); ea.push_back(1'b1);
      end else begin
        eb.push_back(p); ea.push_back(1'b0);
      end
    end
    slots = hit ? (r ? 29 : 20) : 11 * att;
    rd0 = d0; rd1 = d1;
    bus_q.delete(); ack_q.delete(); starts = 0; stops = 0;
    @(negedge clock);
    Go = 1'b1; RdWr = r; SlaveAddr = addr; PtrByte = p;
    @(posedge clock); cyc = 1;
    @(negedge clock);
    if (!hold) Go = 1'b0;
    RdWr = ~r; SlaveAddr = ~addr; PtrByte = ~p;
    check("busy_on", 32'(Busy), 1);
    check("load_addr", 32'({WriteLoad, SentData}), 32'({1'b1, ab}));
    busy_low = 0;
    while (!Done && cyc < 16 * slots + 64) begin
      @(posedge clock); cyc++;
      @(negedge clock);
      if (!Busy && !Done) busy_low++;
    end
    check("latency", cyc, 16 * slots + 1);
    check("ack_error", 32'(AckError), 32'(!hit));
    if (hit && r) rx_model = {d0, d1};
    check("rx_data", 32'(RxData), 32'(rx_model));
    check("n_bytes", bus_q.size(), eb.size());
    for (int i = 0; i < eb.size() && i < bus_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(bus_q[i]), 32'(eb[i]));
    check("n_acks", ack_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ack_q.size(); i++)
      check($sformatf("ack%0d", i), 32'(ack_q[i]), 32'(ea[i]));
    check("starts", starts, att);
    check("stops", stops, att);
    check("busy_low", busy_low, 0);
  endtask

  initial begin
    int cyc;
    bit hit;
    logic [6:0] a;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_scl", 32'(SCL), 1);
    check("rst_sel", 32'(Select), 1);
    check("rst_ssa", 32'(StartStopAck), 1);
    check("rst_row", 32'(ReadOrWrite), 0);
    check("rst_ctl", 32'({WriteLoad, ShiftorHold, Busy, Done, AckError}), 0);
    check("rst_rx", 32'(RxData), 0);
    check("rst_sent", 32'(SentData), 0);
    Reset = 1'b1;
    repeat (2) @(posedge clock);

    run_txn(1'b1, SLV, 8'h00, 8'h19, 8'h00, 1'b0);
    run_txn(1'b0, SLV, 8'h01, 8'hAA, 8'h55, 1'b0);
    run_txn(1'b1, 7'h4F, 8'h00, 8'h12, 8'h34, 1'b0);

    for (int k = 0; k < 6; k++) begin
      hit = $urandom_range(0, 2) != 0;
      a = 7'($urandom);
      if (a == SLV) a = a ^ 7'h01;
      run_txn(1'($urandom), hit ? SLV : a, 8'($urandom),
              8'($urandom), 8'($urandom), 1'b0);
    end

    rd0 = 8'hC3; rd1 = 8'h3C;
    bus_q.delete(); ack_q.delete();
    @(negedge clock);
    Go = 1'b1; RdWr = 1'b1; SlaveAddr = SLV;
    @(posedge clock);
    @(negedge clock); Go = 1'b0;
    repeat (232) @(posedge clock);
    @(negedge clock);
    check("pre_rst_row", 32'(ReadOrWrite), 1);
    check("pre_rst_busy", 32'(Busy), 1);
    #1 Reset = 1'b0;
    #1;
    check("mid_rst_scl", 32'(SCL), 1);
    check("mid_rst_sel", 32'(Select), 1);
    check("mid_rst_ssa", 32'(StartStopAck), 1);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_row", 32'(ReadOrWrite), 0);
    rx_model = '0;
    check("mid_rst_rx", 32'(RxData), 0);
    repeat (2) @(posedge clock);
    @(negedge clock); Reset = 1'b1;
    repeat (2) @(posedge clock);
    run_txn(1'b1, SLV, 8'h00, 8'h7F, 8'h80, 1'b0);

    run_txn(1'b1, SLV, 8'h00, 8'h19, 8'h00, 1'b1);
    @(posedge clock); @(negedge clock);
    check("held_idle", 32'({Busy, Done}), 0);
    @(posedge clock); @(negedge clock);
    check("held_restart", 32'(Busy), 1);
    Go = 1'b0;
    cyc = 0;
    while (!Done && cyc < 16 * 11 * TRIES + 64) begin
      @(posedge clock); cyc++;
      @(negedge clock);
    end
    check("held_second_done", 32'(Done), 1);
    check("held_second_err", 32'(AckError), 1);
    check("held_second_rx", 32'(RxData), 32'(rx_model));
    repeat (4) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
